// File: rtl/core_pkg.sv
`timescale 1ns/1ps
// Shared core definitions: ALU/decoder operation codes, EX/MEM skid-buffer states and entry layout.
// Combinational helpers only; no timing or backpressure behaviour of its own.
package core_pkg;

    typedef logic [5:0] op_t;

    localparam op_t ADD   = 6'd0;
    localparam op_t SUB   = 6'd1;
    localparam op_t AND   = 6'd2;
    localparam op_t OR    = 6'd3;
    localparam op_t XOR   = 6'd4;
    localparam op_t NOR   = 6'd5;
    localparam op_t SLL   = 6'd6;
    localparam op_t SRL   = 6'd7;
    localparam op_t SRA   = 6'd8;
    localparam op_t SLT   = 6'd9;
    localparam op_t SLTU  = 6'd10;
    localparam op_t ADDI  = 6'd11;
    localparam op_t ANDI  = 6'd12;
    localparam op_t ORI   = 6'd13;
    localparam op_t XORI  = 6'd14;
    localparam op_t SLLI  = 6'd15;
    localparam op_t SRLI  = 6'd16;
    localparam op_t SRAI  = 6'd17;
    localparam op_t SLTI  = 6'd18;
    localparam op_t SLTIU = 6'd19;
    localparam op_t LUI   = 6'd20;
    localparam op_t AUIPC = 6'd21;
    localparam op_t MUL   = 6'd22;
    localparam op_t LW    = 6'd23;
    localparam op_t SW    = 6'd24;
    localparam op_t JR    = 6'd25;
    localparam op_t JALR  = 6'd26;
    localparam op_t JAL   = 6'd27;
    localparam op_t BEQ   = 6'd28;
    localparam op_t BNE   = 6'd29;
    localparam op_t BLT   = 6'd30;
    localparam op_t BGE   = 6'd31;
    localparam op_t BLTU  = 6'd32;
    localparam op_t BGEU  = 6'd33;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wb_en;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] store_data;
    } mem_entry_t;

    // Register writeback happens for plain ALU ops, loads and the linking jumps.
    function automatic logic op_writes_back(input op_t op);
        return (op <= LW) || (op == JALR) || (op == JAL);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
`timescale 1ns/1ps
// Conditional-branch evaluator for BEQ..BGEU; zero for any other code.
// Purely combinational, no latency, no flow control.
module branch_cmp
    import core_pkg::*;
(
    input  logic [5:0]  alu_select,
    input  logic [31:0] alu_result,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        cond
);

    always_comb begin
        cond = 1'b0;
        case (alu_select)
            BEQ:     cond = (alu_result == 32'd0);
            BNE:     cond = (alu_result != 32'd0);
            BLT:     cond = ($signed(operand1) <  $signed(operand2));
            BGE:     cond = ($signed(operand1) >= $signed(operand2));
            BLTU:    cond = (operand1 <  operand2);
            BGEU:    cond = (operand1 >= operand2);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
`timescale 1ns/1ps
// EX->MEM 2-entry skid buffer with writeback/memory decode and registered branch redirect.
// 1-cycle latency when empty; in_ready registered, drops while both entries are held; flush empties.
module ex_mem_stage
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  alu_select,
    input  logic [31:0] alu_result,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [31:0] pc,
    input  logic [31:0] br_offset,
    input  logic [4:0]  rd,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_wb_en,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic [31:0] out_store_data,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    skid_state_t state_q, state_d;
    mem_entry_t  head_q, head_d;
    mem_entry_t  tail_q, tail_d;
    logic        in_ready_q, in_ready_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        br_cond;
    logic        is_jump;
    logic        taken;
    logic [31:0] target;
    logic        in_fire;
    logic        out_fire;
    mem_entry_t  new_entry;

    branch_cmp u_branch_cmp (
        .alu_select (alu_select),
        .alu_result (alu_result),
        .operand1   (operand1),
        .operand2   (operand2),
        .cond       (br_cond)
    );

    assign is_jump = (alu_select == JR) || (alu_select == JALR) || (alu_select == JAL);
    assign taken   = is_jump || br_cond;

    always_comb begin
        target = pc + br_offset;
        case (alu_select)
            JR, JAL: target = alu_result;
            JALR:    target = {alu_result[31:1], 1'b0};
            default: target = pc + br_offset;
        endcase
    end

    always_comb begin
        new_entry.result     = ((alu_select == JALR) || (alu_select == JAL)) ? (pc + 32'd4) : alu_result;
        new_entry.rd         = rd;
        new_entry.wb_en      = op_writes_back(alu_select) && (rd != 5'd0);
        new_entry.mem_rd     = (alu_select == LW);
        new_entry.mem_wr     = (alu_select == SW);
        new_entry.store_data = operand2;
    end

    // Flush wins over both handshakes in the same cycle.
    assign in_fire  = in_valid && in_ready_q && !flush;
    assign out_fire = (state_q != EMPTY) && out_ready && !flush;

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        redirect_d    = in_fire && taken;
        redirect_pc_d = redirect_pc_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        head_d  = new_entry;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d = TWO;
                        tail_d  = new_entry;
                    end else if (in_fire && out_fire) begin
                        head_d  = new_entry;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        head_d  = tail_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        if (redirect_d) begin
            redirect_pc_d = target;
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            head_q        <= '0;
            tail_q        <= '0;
            in_ready_q    <= 1'b1;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            in_ready_q    <= in_ready_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = (state_q != EMPTY);
    assign out_result     = head_q.result;
    assign out_rd         = head_q.rd;
    assign out_wb_en      = head_q.wb_en;
    assign out_mem_rd     = head_q.mem_rd;
    assign out_mem_wr     = head_q.mem_wr;
    assign out_store_data = head_q.store_data;
    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
`timescale 1ns/1ps
// Scoreboard bench for ex_mem_stage: driver pushes expected entries on accept, monitor pops on output transfer.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  alu_select = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic [31:0] pc = '0;
    logic [31:0] br_offset = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic [31:0] out_store_data;
    logic        redirect;
    logic [31:0] redirect_pc;

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_select     (alu_select),
        .alu_result     (alu_result),
        .operand1       (operand1),
        .operand2       (operand2),
        .pc             (pc),
        .br_offset      (br_offset),
        .rd             (rd),
        .flush          (flush),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .out_wb_en      (out_wb_en),
        .out_mem_rd     (out_mem_rd),
        .out_mem_wr     (out_mem_wr),
        .out_store_data (out_store_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wb;
        logic        mrd;
        logic        mwr;
        logic [31:0] sd;
    } exp_t;

    exp_t        exp_q[$];
    logic        model_rdy = 1'b1;
    logic        exp_redir = 1'b0;
    logic [31:0] exp_rpc = 32'd0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic exp_t ref_entry(input int op, input logic [31:0] res, input logic [31:0] b,
                                       input logic [31:0] p, input logic [4:0] d);
        exp_t e;
        e.res = (op == 26 || op == 27) ? p + 32'd4 : res;
        e.rd  = d;
        e.wb  = ((op <= 23) || op == 26 || op == 27) && (d != 5'd0);
        e.mrd = (op == 23);
        e.mwr = (op == 24);
        e.sd  = b;
        return e;
    endfunction

    function automatic logic ref_taken(input int op, input logic [31:0] res,
                                       input logic [31:0] a, input logic [31:0] b);
        case (op)
            25, 26, 27: return 1'b1;
            28: return res == 0;
            29: return res != 0;
            30: return $signed(a) < $signed(b);
            31: return $signed(a) >= $signed(b);
            32: return a < b;
            33: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input int op, input logic [31:0] res,
                                               input logic [31:0] p, input logic [31:0] off);
        if (op == 25 || op == 27) return res;
        if (op == 26) return res & 32'hFFFF_FFFE;
        return p + off;
    endfunction

    // One cycle of stimulus; the acceptance decision uses the model's own occupancy.
    task automatic drive(input logic v, input logic [5:0] sel, input logic [31:0] res,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                         input logic [31:0] off, input logic [4:0] d, input logic fl, input logic ordy);
        logic acc;
        @(posedge clk);
        #1;
        in_valid = v; alu_select = sel; alu_result = res; operand1 = a; operand2 = b;
        pc = p; br_offset = off; rd = d; flush = fl; out_ready = ordy;
        #6;
        acc = v && model_rdy && !fl && rst_n;
        if (fl) exp_q.delete();
        if (acc) exp_q.push_back(ref_entry(int'(sel), res, b, p, d));
        exp_redir = acc && ref_taken(int'(sel), res, a, b);
        if (exp_redir) exp_rpc = ref_target(int'(sel), res, p, off);
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, ordy);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_redirect", redirect, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_store_data", out_store_data, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        exp_q.delete();
        exp_redir = 1'b0;
        exp_rpc = 32'd0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: compares the DUT against the model on every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_q.size() < 2);
            chk("redirect", redirect, exp_redir);
            chk("redirect_pc", redirect_pc, exp_rpc);
            model_rdy = (exp_q.size() < 2);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                if (out_valid) begin
                    chk("out_result", out_result, e.res);
                    chk("out_rd", out_rd, e.rd);
                    chk("out_wb_en", out_wb_en, e.wb);
                    chk("out_mem_rd", out_mem_rd, e.mrd);
                    chk("out_mem_wr", out_mem_wr, e.mwr);
                    chk("out_store_data", out_store_data, e.sd);
                end
                if (out_ready && !flush && rst_n) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [5:0]  s;
        logic [31:0] r, a, b;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single ADD, 1-cycle latency
        drive(1'b1, 6'd0, 32'd3, 32'd1, 32'd2, 32'h10, 32'd0, 5'd5, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: 10, 11 held, 12 refused until space frees
        drive(1'b1, 6'd1, 32'd10, 32'd0, 32'd7, 32'h20, 32'd0, 5'd6, 1'b0, 1'b0);
        drive(1'b1, 6'd1, 32'd11, 32'd0, 32'd8, 32'h24, 32'd0, 5'd7, 1'b0, 1'b0);
        drive(1'b1, 6'd1, 32'd12, 32'd0, 32'd9, 32'h28, 32'd0, 5'd8, 1'b0, 1'b0);
        drive(1'b1, 6'd1, 32'd12, 32'd0, 32'd9, 32'h28, 32'd0, 5'd8, 1'b0, 1'b1);
        drive(1'b1, 6'd1, 32'd12, 32'd0, 32'd9, 32'h28, 32'd0, 5'd8, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Signed vs unsigned less-than with the same operands
        drive(1'b1, 6'd30, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd0, 1'b0, 1'b1);
        idle(1'b1);
        drive(1'b1, 6'd32, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd0, 1'b0, 1'b1);
        idle(1'b1);

        // JALR link and aligned target; then load/store decode
        drive(1'b1, 6'd26, 32'h205, 32'd0, 32'd0, 32'h40, 32'd0, 5'd1, 1'b0, 1'b1);
        drive(1'b1, 6'd23, 32'h1000, 32'd0, 32'hAB, 32'h44, 32'd0, 5'd2, 1'b0, 1'b1);
        drive(1'b1, 6'd24, 32'h1004, 32'd0, 32'hCD, 32'h48, 32'd0, 5'd3, 1'b0, 1'b1);
        drive(1'b1, 6'd0, 32'h77, 32'd0, 32'd0, 32'h4C, 32'd0, 5'd0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while full, with a competing input
        drive(1'b1, 6'd0, 32'd21, 32'd0, 32'd0, 32'h60, 32'd0, 5'd4, 1'b0, 1'b0);
        drive(1'b1, 6'd0, 32'd22, 32'd0, 32'd0, 32'h64, 32'd0, 5'd4, 1'b0, 1'b0);
        drive(1'b1, 6'd27, 32'h300, 32'd0, 32'd0, 32'h68, 32'd0, 5'd4, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset while one entry is held
        drive(1'b1, 6'd25, 32'h400, 32'd0, 32'd0, 32'h70, 32'd0, 5'd9, 1'b0, 1'b0);
        async_reset();
        drive(1'b1, 6'd0, 32'd55, 32'd0, 32'd0, 32'h80, 32'd0, 5'd9, 1'b0, 1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            s = 6'($urandom_range(0, 40));
            r = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive($urandom_range(0, 3) != 0, s, r, a, b, $urandom, $urandom, 5'($urandom),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end

        repeat (4) idle(1'b1);
        @(negedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
